// File: rtl/aca_varlat_adder.sv
// aca_varlat_adder: key-locked, variable-latency almost-correct adder.
// Each sum bit uses a carry built only from the WIN bits below it.
// Possible speculation errors are flagged. In correct mode, one extra
// cycle produces the exact sum.
// Optional macro ACA_ERR_CNT_EN enables a saturating 16-bit count of
// detected errors on err_cnt_o.
module aca_varlat_adder #(
  parameter int               WIDTH = 16,
  parameter int               WIN   = 4,
  parameter int               KEY_W = 32,
  parameter logic [KEY_W-1:0] KEY   = 32'h184B8236
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] keyinput,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result_o,
  output logic             err_o,
  output logic             corrected_o,
  output logic [15:0]      err_cnt_o
);

  localparam int NE = WIDTH - WIN + 1;

  typedef enum logic [1:0] {IDLE, CORR, OUT} state_t;

  state_t           state_reg;
  logic [WIDTH:0]   exact_reg;

  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   approx;
  logic [WIDTH:0]   exact;
  logic [NE-1:0]    err_vec;
  logic             err;
  logic [KEY_W-1:0] key_diff;
  logic             key_ok;
  logic [WIDTH:0]   mask;
  logic             accept;

  assign p = add1_i ^ add2_i;

  // carry[i]: carry into bit i from a window of at most WIN lower bits, cin 0
  assign carry[0] = 1'b0;
  generate
    for (genvar gi = 1; gi <= WIDTH; gi++) begin : g_win
      localparam int LO  = (gi > WIN) ? gi - WIN : 0;
      localparam int LEN = gi - LO;
      assign carry[gi] = 1'(({1'b0, add1_i[LO +: LEN]} + {1'b0, add2_i[LO +: LEN]}) >> LEN);
    end
  endgenerate

  assign approx = {carry[WIDTH], p ^ carry[WIDTH-1:0]};
  assign exact  = {1'b0, add1_i} + {1'b0, add2_i};

  // A full-propagate run of WIN bits below bit i means the window may miss a carry
  generate
    for (genvar gi = 0; gi < NE; gi++) begin : g_err
      assign err_vec[gi] = &p[gi +: WIN];
    end
  endgenerate
  assign err = |err_vec;

  assign key_diff = keyinput ^ KEY;
  assign key_ok   = (key_diff == '0);
  assign mask     = key_ok ? '0 : key_diff[WIDTH:0];

  assign in_ready = (state_reg == IDLE) || ((state_reg == OUT) && out_ready);
  assign accept   = in_valid && in_ready;

  // Control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      out_valid   <= 1'b0;
      result_o    <= '0;
      err_o       <= 1'b0;
      corrected_o <= 1'b0;
      exact_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, OUT: begin
          if (accept) begin
            result_o    <= approx ^ mask;
            err_o       <= err;
            corrected_o <= 1'b0;
            exact_reg   <= exact;
            if (mode_i && err) begin
              state_reg <= CORR;
              out_valid <= 1'b0;
            end else begin
              state_reg <= OUT;
              out_valid <= 1'b1;
            end
          end else if ((state_reg == OUT) && out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
          end
        end
        CORR: begin
          result_o    <= exact_reg ^ mask;
          corrected_o <= 1'b1;
          out_valid   <= 1'b1;
          state_reg   <= OUT;
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACA_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Saturating count of accepted pairs flagged as possible errors
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (accept && err && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_reg;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_aca_varlat_adder.sv
// Testbench for aca_varlat_adder: a table of directed vectors,
// hand-written backpressure and reset sequences, and randomized
// transactions checked against a behavioural model.
module tb_aca_varlat_adder;

  localparam int          WIDTH = 16;
  localparam int          WIN   = 4;
  localparam logic [31:0] KEY   = 32'h184B8236;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] keyinput;
  logic        in_valid;
  logic        in_ready;
  logic        mode_i;
  logic [15:0] add1_i;
  logic [15:0] add2_i;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] result_o;
  logic        err_o;
  logic        corrected_o;
  logic [15:0] err_cnt_o;

  int passed = 0;
  int total  = 0;
  int model_errs = 0;

  always #5 clk = ~clk;

  aca_varlat_adder dut (
    .clk(clk), .rst_n(rst_n), .keyinput(keyinput), .in_valid(in_valid),
    .in_ready(in_ready), .mode_i(mode_i), .add1_i(add1_i), .add2_i(add2_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
    .err_o(err_o), .corrected_o(corrected_o), .err_cnt_o(err_cnt_o)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
    logic [31:0] key;
    logic [16:0] res;
    logic        err;
    logic        corr;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  // Approximate sum: bit i is bit (i-lo) of the sum of the operand slices lo..i
  function automatic logic [16:0] model_approx(input logic [15:0] a, input logic [15:0] b);
    longint unsigned aa, bb, s, m;
    int lo;
    logic [16:0] r;
    aa = 64'(a);
    bb = 64'(b);
    r = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      lo = (i > WIN) ? i - WIN : 0;
      m = (64'd1 << (i - lo + 1)) - 64'd1;
      s = ((aa >> lo) & m) + ((bb >> lo) & m);
      r[i] = s[i - lo];
    end
    return r;
  endfunction

  function automatic logic model_err(input logic [15:0] a, input logic [15:0] b);
    longint unsigned p, ones;
    logic e;
    p = 64'(a ^ b);
    ones = (64'd1 << WIN) - 64'd1;
    e = 1'b0;
    for (int i = WIN; i <= WIDTH; i++)
      if (((p >> (i - WIN)) & ones) == ones) e = 1'b1;
    return e;
  endfunction

  function automatic logic [16:0] model_mask(input logic [31:0] key);
    logic [31:0] d;
    d = key ^ KEY;
    return (key == KEY) ? 17'h0 : d[16:0];
  endfunction

  task automatic count_err_cnt(input string nm);
`ifdef ACA_ERR_CNT_EN
    chk(nm, 32'(err_cnt_o), 32'(model_errs > 65535 ? 65535 : model_errs));
`else
    chk(nm, 32'(err_cnt_o), 32'd0);
`endif
  endtask

  // One transaction from IDLE: accept, wait for result, check, release
  task automatic run_txn(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic mode, input logic [31:0] key,
                         input logic [16:0] xres, input logic xerr, input logic xcorr,
                         input int xlat, input int hold);
    int lat;
    @(negedge clk);
    add1_i = a; add2_i = b; mode_i = mode; keyinput = key;
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (model_err(a, b)) model_errs++;
    lat = 1;
    while (!out_valid && lat < 6) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".lat"}, 32'(lat), 32'(xlat));
    chk({nm, ".result"}, 32'(result_o), 32'(xres));
    chk({nm, ".err"}, 32'(err_o), 32'(xerr));
    chk({nm, ".corr"}, 32'(corrected_o), 32'(xcorr));
    $display("txn %s a=%h b=%h mode=%0d key=%h res=%h err=%0d corr=%0d lat=%0d",
             nm, a, b, mode, key, result_o, err_o, corrected_o, lat);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_res"}, 32'(result_o), 32'(xres));
      chk({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, ".release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rm;
    logic [31:0] rk;
    logic        re;
    logic [16:0] rx;

    vecs[0] = '{16'h1234, 16'h1111, 1'b0, KEY,   17'h02345, 1'b0, 1'b0, 1};
    vecs[1] = '{16'h00FF, 16'h0001, 1'b0, KEY,   17'h000E0, 1'b1, 1'b0, 1};
    vecs[2] = '{16'h00FF, 16'h0001, 1'b1, KEY,   17'h00100, 1'b1, 1'b1, 2};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b1, KEY,   17'h10000, 1'b1, 1'b1, 2};
    vecs[4] = '{16'h1234, 16'h1111, 1'b0, 32'h0, 17'h1A173, 1'b0, 1'b0, 1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, KEY,   17'h0FFE0, 1'b1, 1'b0, 1};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, KEY,   17'h1FFFE, 1'b0, 1'b0, 1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, KEY,   17'h00000, 1'b0, 1'b0, 1};

    rst_n = 1'b0; keyinput = KEY; in_valid = 1'b0; mode_i = 1'b0;
    add1_i = '0; add2_i = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", 32'(result_o), 32'd0);
    chk("reset.err", 32'(err_o), 32'd0);
    chk("reset.corr", 32'(corrected_o), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    count_err_cnt("reset.err_cnt");
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].key,
              vecs[i].res, vecs[i].err, vecs[i].corr, vecs[i].lat, 0);
    end
    count_err_cnt("table.err_cnt");

    // Backpressure for 3 cycles, then back-to-back accept
    @(negedge clk);
    add1_i = 16'h1234; add2_i = 16'h1111; mode_i = 1'b0; keyinput = KEY;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp.valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.result", 32'(result_o), 32'h02345);
      chk("bp.valid_hold", 32'(out_valid), 32'd1);
    end
    add1_i = 16'h0F0F; add2_i = 16'h0101; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.valid", 32'(out_valid), 32'd1);
    chk("b2b.result", 32'(result_o), 32'(model_approx(16'h0F0F, 16'h0101)));
    chk("b2b.err", 32'(err_o), 32'(model_err(16'h0F0F, 16'h0101)));
    $display("txn b2b a=0f0f b=0101 res=%h err=%0d", result_o, err_o);
    if (model_err(16'h1234, 16'h1111)) model_errs++;
    if (model_err(16'h0F0F, 16'h0101)) model_errs++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b.release", 32'(out_valid), 32'd0);

    // Reset while in the correction cycle
    @(negedge clk);
    add1_i = 16'h00FF; add2_i = 16'h0001; mode_i = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstcorr.in_corr_valid", 32'(out_valid), 32'd0);
    chk("rstcorr.in_corr_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_errs = 0;
    chk("rstcorr.valid", 32'(out_valid), 32'd0);
    chk("rstcorr.in_ready", 32'(in_ready), 32'd1);
    chk("rstcorr.result", 32'(result_o), 32'd0);
    count_err_cnt("rstcorr.err_cnt");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rstcorr.no_emit", 32'(out_valid), 32'd0);
    end
    $display("txn rstcorr a=00ff b=0001 discarded");

    // Randomized transactions against the model
    for (int n = 0; n < 120; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? (~ra ^ 16'(1 << $urandom_range(0, 15))) : 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      rk = ($urandom_range(0, 2) == 0) ? $urandom : KEY;
      re = model_err(ra, rb);
      rx = ((rm && re) ? ({1'b0, ra} + {1'b0, rb}) : model_approx(ra, rb)) ^ model_mask(rk);
      run_txn($sformatf("rnd%0d", n), ra, rb, rm, rk, rx, re, rm && re,
              (rm && re) ? 2 : 1, (n % 10 == 0) ? 2 : 0);
    end
    count_err_cnt("final.err_cnt");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aca_varlat_adder.md
Name: aca_varlat_adder

Overview:
Parametrised, key-locked, variable-latency almost-correct adder with a valid/ready handshake on input and output.
- Produces a speculative sum in which each bit's carry is built only from the WIN bits below it.
- Flags possible speculation errors and, in correct mode, spends one extra cycle producing the exact sum.
- Sits in the locked-arithmetic datapath as the sequential successor of the 16-bit combinational almost-correct adder.

Parameters:
WIDTH, 16, operand width in bits (>= WIN+1)
WIN, 4, carry speculation window in bits (1..WIDTH-1)
KEY_W, 32, key input width (>= WIDTH+1)
KEY, 32'h184B8236, correct unlock key

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
keyinput  in  KEY_W  locking key
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
mode_i  in  1  0 = approximate only, 1 = correct on detected error
add1_i  in  WIDTH  operand A
add2_i  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result_o  out  WIDTH+1  sum, MSB = carry out
err_o  out  1  speculation error detected for this result
corrected_o  out  1  result went through correction cycle
err_cnt_o  out  16  detected-error count (see optional feature)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; out_valid, result_o, err_o, corrected_o and err_cnt_o all 0.
  - Reset mid-operation (CORR or OUT) discards the pending result, with no output handshake.
- Definitions, per accepted operand pair:
  - p = A^B, g = A&B.
  - Approximate sum bit i (0..WIDTH-1) = p[i] ^ c_i.
  - c_i = exact carry into bit i computed from bits max(0,i-WIN)..i-1, with carry-in 0 at the window start.
  - Approximate result bit WIDTH = carry out of bits WIDTH-WIN..WIDTH-1, again with window carry-in 0.
  - Exact sum = A+B, zero-extended to WIDTH+1 bits.
  - err = 1 iff some i in WIN..WIDTH has p[i-WIN..i-1] all 1. This detector is conservative: err may be 1 even when approx == exact.
- Lock:
  - key_ok = (keyinput == KEY).
  - mask = key_ok ? 0 : (keyinput ^ KEY)[WIDTH:0].
  - Every value written to result_o is XORed with mask, using the keyinput value at the write edge.
- States:
  - IDLE: in_ready=1.
    - On in_valid, latch: result = approx^mask, err_o = err, corrected_o = 0; mode_i is sampled here.
    - If mode_i=1 and err=1, go to CORR; else go to OUT.
  - CORR: in_ready=0, out_valid=0.
    - Next edge: result = exact^mask, corrected_o = 1, go to OUT.
  - OUT: out_valid=1; result_o, err_o and corrected_o are held stable while out_ready=0.
    - in_ready = out_ready.
    - On out_ready with in_valid: accept the new pair exactly as in IDLE (back-to-back, no bubble).
    - On out_ready without in_valid: go to IDLE.
- Latency from the accept edge to out_valid:
  - 1 cycle when no correction is taken.
  - 2 cycles when correction is taken.
  - Throughput is 1 result per cycle when no correction is taken.
- The input handshake ignores keyinput changes; the output mask is fixed at capture.

Optional Feature:
ACA_ERR_CNT_EN:
- Defined: err_cnt_o is a 16-bit counter, incremented on each accept whose err=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
  - Counts in both modes.
- Not defined: err_cnt_o is tied to 0 and no counter logic exists.

Test Plan:
- Defaults, key correct, mode 0: A=16'h1234, B=16'h1111 -> out_valid one cycle after accept, result_o=17'h02345, err_o=0, corrected_o=0.
- Mode 0: A=16'h00FF, B=16'h0001 -> result_o=17'h000E0, err_o=1, corrected_o=0, 1-cycle latency. With ACA_ERR_CNT_EN: err_cnt_o=1.
- Mode 1, same operands -> out_valid 2 cycles after accept, result_o=17'h00100, err_o=1, corrected_o=1. Also mode 1 with A=16'hFFFF, B=16'h0001 -> result_o=17'h10000, corrected_o=1.
- Key wrong (keyinput=0), mode 0: A=16'h1234, B=16'h1111 -> result_o=17'h1A173 (17'h02345 ^ 17'h18236).
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles: result_o stable and in_ready=0 throughout.
  - Then out_ready=1 with a new in_valid pair: new pair accepted the same cycle; next result valid the following cycle.
- Reset while in CORR -> next cycle out_valid=0, in_ready=1, result_o=0, and no result is emitted for the discarded pair.
